// File: rtl/pipelined_ripple_adder_if.sv
// Operand/result valid-ready bundle for pipelined_ripple_adder.
// The master side drives operands and out_ready; the slave side is the adder.
interface pipelined_ripple_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/pipelined_ripple_adder.sv
// WIDTH-bit add/subtract built from STAGES ripple segments with a register
// between segments; the whole pipe freezes while the result is back-pressured.
module pipelined_ripple_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  pipelined_ripple_adder_if.slave bus
);
  localparam int SEG = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_ripple_adder: illegal WIDTH/STAGES combination");
  end

  // One SEG-bit ripple segment; returns {carry_out, sum}.
  function automatic logic [SEG:0] ripple(input logic [SEG-1:0] x,
                                          input logic [SEG-1:0] y,
                                          input logic           c);
    logic [SEG:0]   cy;
    logic [SEG-1:0] s;
    cy[0] = c;
    for (int i = 0; i < SEG; i++) begin
      s[i]    = x[i] ^ y[i] ^ cy[i];
      cy[i+1] = (x[i] & y[i]) | (cy[i] & (x[i] ^ y[i]));
    end
    return {cy[SEG], s};
  endfunction

  logic [STAGES-1:0] valid_r;
  logic [WIDTH-1:0]  sum_r;
  logic              cout_r;
  logic              ovf_r;
  logic              zero_r;
  logic              adv_s;

  assign adv_s         = !valid_r[STAGES-1] || bus.out_ready;
  assign bus.in_ready  = adv_s || rst;
  assign bus.out_valid = valid_r[STAGES-1];
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;
  assign bus.zero      = zero_r;

  // Valid bits march with the data; bubbles are kept, not collapsed.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= {STAGES{1'b0}};
    end else if (adv_s) begin
      valid_r[0] <= bus.in_valid;
      for (int k = 1; k < STAGES; k++) begin
        valid_r[k] <= valid_r[k-1];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;
    localparam int HI = LO + SEG;

    logic [WIDTH-LO-1:0] opa_s;
    logic [WIDTH-LO-1:0] opb_s;
    logic                cin_s;
    logic [SEG:0]        seg_s;
    logic [HI-1:0]       sum_next_s;

    // Stage 0 does the subtract inversion; later stages take the previous stage's registers.
    if (k == 0) begin : g_src
      assign opa_s      = bus.a;
      assign opb_s      = bus.sub ? ~bus.b : bus.b;
      assign cin_s      = bus.sub ? ~bus.cin : bus.cin;
      assign sum_next_s = seg_s[SEG-1:0];
    end else begin : g_src
      assign opa_s      = g_stage[k-1].g_keep.opa_r;
      assign opb_s      = g_stage[k-1].g_keep.opb_r;
      assign cin_s      = g_stage[k-1].g_keep.carry_r;
      assign sum_next_s = {seg_s[SEG-1:0], g_stage[k-1].g_keep.skew_r};
    end

    assign seg_s = ripple(opa_s[SEG-1:0], opb_s[SEG-1:0], cin_s);

    if (k < STAGES - 1) begin : g_keep
      logic [WIDTH-HI-1:0] opa_r;
      logic [WIDTH-HI-1:0] opb_r;
      logic [HI-1:0]       skew_r;
      logic                carry_r;

      // Hand finished low sums, the segment carry and untouched upper bits onward.
      always_ff @(posedge clk) begin
        if (rst) begin
          opa_r   <= {(WIDTH-HI){1'b0}};
          opb_r   <= {(WIDTH-HI){1'b0}};
          skew_r  <= {HI{1'b0}};
          carry_r <= 1'b0;
        end else if (adv_s) begin
          opa_r   <= opa_s[WIDTH-LO-1:SEG];
          opb_r   <= opb_s[WIDTH-LO-1:SEG];
          skew_r  <= sum_next_s;
          carry_r <= seg_s[SEG];
        end
      end
    end else begin : g_last
      logic cmsb_s;

      // Carry into the MSB is recovered from its sum bit: s = a ^ b ^ c.
      assign cmsb_s = opa_s[SEG-1] ^ opb_s[SEG-1] ^ seg_s[SEG-1];

      // Final stage owns the result and flag registers.
      always_ff @(posedge clk) begin
        if (rst) begin
          sum_r  <= {WIDTH{1'b0}};
          cout_r <= 1'b0;
          ovf_r  <= 1'b0;
          zero_r <= 1'b0;
        end else if (adv_s) begin
          sum_r  <= sum_next_s;
          cout_r <= seg_s[SEG];
          ovf_r  <= cmsb_s ^ seg_s[SEG];
          zero_r <= ~|sum_next_s;
        end
      end
    end
  end
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Scoreboard bench: directed hand-computed vectors on a 16/4 instance plus
// random sweeps of (4,1), (8,2), (32,8) instances against an arithmetic model.
module tb_pipelined_ripple_adder;
  localparam int W           = 16;
  localparam int S           = 4;
  localparam int SWEEP_BEATS = 10000;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  logic sw_rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t vecs[12];
  res_t exp_q[$];

  always #5 clk = ~clk;

  pipelined_ripple_adder_if #(.WIDTH(W)) bus ();
  pipelined_ripple_adder #(.WIDTH(W), .STAGES(S)) u_dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Control inputs must be known whenever reset is low.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      assert (!$isunknown({bus.in_valid, bus.out_ready, bus.cin, bus.sub}))
      else begin
        n_fail++;
        $display("FAIL ctrl_x: control input unknown while out of reset");
      end
    end
  end

  // Monitor: every retired result must match the head of the scoreboard.
  always @(negedge clk) begin
    res_t e;
    if (rst === 1'b0 && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result: got sum 0x%0h with no beat outstanding", bus.sum);
      end else begin
        e = exp_q.pop_front();
        check("result", 64'({bus.sum, bus.cout, bus.ovf, bus.zero}), 64'(e));
      end
    end
  end

  task automatic send(input int idx, input bit expect_out);
    bus.a        = vecs[idx].a;
    bus.b        = vecs[idx].b;
    bus.cin      = vecs[idx].cin;
    bus.sub      = vecs[idx].sub;
    bus.in_valid = 1'b1;
    if (expect_out) exp_q.push_back({vecs[idx].sum, vecs[idx].cout, vecs[idx].ovf, vecs[idx].zero});
    @(negedge clk);
    for (int t = 0; t < 50 && !bus.in_ready; t++) @(negedge clk);
    if (!bus.in_ready) check("send_timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic single_latency(input int idx, input string name);
    send(idx, 1'b1);
    for (int k = 0; k < S; k++) begin
      @(negedge clk);
      check({name, "_out_valid"}, 64'(bus.out_valid), 64'(k == S - 1));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    sw_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sw_rst = 1'b0;
  end

  // Directed stimulus for the 16-bit / 4-stage instance.
  initial begin
    vecs[0]  = '{16'h1234, 16'h0FED, 1'b1, 1'b0, 16'h2222, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{16'h0000, 16'hFFFF, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = 16'h0000;
    bus.b         = 16'h0000;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("post_rst_flags", 64'({bus.sum, bus.cout, bus.ovf, bus.zero}), 64'd0);
    @(posedge clk);
    #1;

    single_latency(0, "add");
    single_latency(1, "wrap");
    single_latency(2, "ovf_add");
    single_latency(3, "sub_neg");
    single_latency(4, "ovf_sub");
    single_latency(5, "sub_equal");
    single_latency(9, "seg_carry");
    single_latency(10, "sub_zero_minus_ones");

    // Back-to-back stream with a 5-cycle output stall in the middle.
    fork
      begin
        for (int i = 0; i < 8; i++) send(i, 1'b1);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check("stall_in_ready", 64'(bus.in_ready), 64'd0);
          check("stall_out_valid", 64'(bus.out_valid), 64'd1);
          if (exp_q.size() != 0)
            check("stall_hold", 64'({bus.sum, bus.cout, bus.ovf, bus.zero}), 64'(exp_q[0]));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain("stream_drain");

    // Reset with three beats in flight plus one presented during reset.
    for (int i = 0; i < 3; i++) send(8 + i, 1'b0);
    rst          = 1'b1;
    bus.a        = vecs[11].a;
    bus.b        = vecs[11].b;
    bus.cin      = vecs[11].cin;
    bus.sub      = vecs[11].sub;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    single_latency(11, "after_rst");
    drain("final_drain");

    for (int t = 0; t < 40000 && !(g_sweep[0].done_b && g_sweep[1].done_b && g_sweep[2].done_b); t++)
      @(posedge clk);
    check("sweeps_done", 64'({g_sweep[0].done_b, g_sweep[1].done_b, g_sweep[2].done_b}), 64'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int SW = (g == 0) ? 4 : (g == 1) ? 8 : 32;
    localparam int SS = (g == 0) ? 1 : (g == 1) ? 2 : 8;

    pipelined_ripple_adder_if #(.WIDTH(SW)) sbus ();
    pipelined_ripple_adder #(.WIDTH(SW), .STAGES(SS)) u_sdut (.clk(clk), .rst(sw_rst), .bus(sbus));

    logic [SW+2:0] sq[$];
    bit            done_b = 1'b0;

    // Reference: {cout, ovf, zero, sum} with ovf from operand/result signs.
    function automatic logic [SW+2:0] model(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                            input logic c, input logic s);
      logic [SW-1:0] ye;
      logic          ce;
      logic [SW:0]   full;
      logic          ov;
      ye   = s ? ~y : y;
      ce   = s ? ~c : c;
      full = {1'b0, x} + {1'b0, ye} + {{SW{1'b0}}, ce};
      ov   = (x[SW-1] == ye[SW-1]) && (full[SW-1] != x[SW-1]);
      return {full[SW], ov, (full[SW-1:0] == {SW{1'b0}}), full[SW-1:0]};
    endfunction

    initial begin
      sbus.out_ready = 1'b1;
      forever begin
        @(posedge clk);
        #1;
        sbus.out_ready = ($urandom_range(0, 3) != 0);
      end
    end

    initial begin
      sbus.in_valid = 1'b0;
      sbus.a        = {SW{1'b0}};
      sbus.b        = {SW{1'b0}};
      sbus.cin      = 1'b0;
      sbus.sub      = 1'b0;
      wait (sw_rst == 1'b0);
      @(posedge clk);
      #1;
      for (int n = 0; n < SWEEP_BEATS; n++) begin
        if ($urandom_range(0, 7) == 0) begin
          sbus.in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
        sbus.a        = SW'($urandom);
        sbus.b        = SW'($urandom);
        sbus.cin      = 1'($urandom);
        sbus.sub      = 1'($urandom);
        sbus.in_valid = 1'b1;
        sq.push_back(model(sbus.a, sbus.b, sbus.cin, sbus.sub));
        @(negedge clk);
        for (int t = 0; t < 50 && !sbus.in_ready; t++) @(negedge clk);
        if (!sbus.in_ready) check($sformatf("sweep%0d_timeout", g), 64'(sbus.in_ready), 64'd1);
        @(posedge clk);
        #1;
      end
      sbus.in_valid = 1'b0;
      for (int t = 0; t < 500 && sq.size() != 0; t++) @(posedge clk);
      check($sformatf("sweep%0d_drain", g), 64'(sq.size()), 64'd0);
      done_b = 1'b1;
    end

    always @(negedge clk) begin
      logic [SW+2:0] e;
      if (sw_rst === 1'b0 && sbus.out_valid && sbus.out_ready) begin
        if (sq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sweep%0d_unexpected: got sum 0x%0h with no beat outstanding", g, sbus.sum);
        end else begin
          e = sq.pop_front();
          check($sformatf("sweep%0d_result", g),
                64'({sbus.cout, sbus.ovf, sbus.zero, sbus.sum}), 64'(e));
        end
      end
    end
  end
endmodule
